midi_out: RTL and testbench

MIDI 1.0 serial transmitter, the outbound counterpart of midi_in: takes a channel message in the same decoded form midi_in produces (CH_MESSAGE, CHAN, data1, data2) and serialises it as 8N1 UART frames at 31250 baud on a single pin. Used for MIDI THRU/echo and for sending controller values from the synth back to a host. Sits on the 50 MHz PLL clock domain next to midi_in.

---
 rtl/midi_pkg.sv | 43 ++++
 rtl/uart_tx_byte.sv | 89 ++++++++
 rtl/midi_out.sv | 146 ++++++++++++++
 tb/tb_midi_out.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: definitions shared by midi_in and midi_out.
//   - MIDI channel-message type nibbles (upper nibble of the status byte)
//   - msg_len(): number of data bytes that follow a status byte of that type
//   - is_channel_msg(): nibble is one of the seven channel-voice messages
//   - DEFAULT_CLK_DIV: clocks per bit for 31250 baud from the 50 MHz PLL clock
//   - midi_out_dbg_t: state snapshot exported by midi_out for checkers
package midi_pkg;

    localparam int DEFAULT_CLK_DIV = 1600;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] POLY_PRESS = 4'hA;
    localparam logic [3:0] CTRL       = 4'hB;
    localparam logic [3:0] PROG       = 4'hC;
    localparam logic [3:0] CH_PRESS   = 4'hD;
    localparam logic [3:0] PITCH      = 4'hE;

    // Data bytes following the status byte; 0 marks a nibble that is not a
    // channel-voice message (0-7 are data, F is system).
    function automatic logic [1:0] msg_len(input logic [3:0] nibble);
        logic [1:0] len;
        case (nibble)
            PROG, CH_PRESS:                             len = 2'd1;
            NOTE_OFF, NOTE_ON, POLY_PRESS, CTRL, PITCH: len = 2'd2;
            default:                                    len = 2'd0;
        endcase
        return len;
    endfunction

    function automatic logic is_channel_msg(input logic [3:0] nibble);
        return msg_len(nibble) != 2'd0;
    endfunction

    typedef struct packed {
        logic [1:0] fsm;        // message-framing FSM state
        logic [1:0] byte_idx;   // byte of the message on the wire (0=status)
        logic [1:0] uart_fsm;   // byte serialiser FSM state
        logic [2:0] bit_cnt;    // data bit being sent
        logic       uart_busy;  // serialiser cannot take a new byte
    } midi_out_dbg_t;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser for one byte.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load tx_byte and begin its start bit on the next cycle
//   tx_byte   : byte to send, LSB first
//   tx        : serial line, idle high
//   busy      : high while a frame is in flight and not in its final cycle
//   done      : high during the final clock of the stop bit
//   state     : FSM state (debug)
//   bit_cnt   : data bit index 0..7 (debug)
//
// start is honoured whenever busy is low, including the last stop-bit cycle,
// so a caller that answers done with start gets frames with no idle gap.
module uart_tx_byte
    import midi_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [1:0] state,
    output logic [2:0] bit_cnt
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

    localparam logic [1:0] U_IDLE  = 2'd0;
    localparam logic [1:0] U_START = 2'd1;
    localparam logic [1:0] U_DATA  = 2'd2;
    localparam logic [1:0] U_STOP  = 2'd3;

    logic [CW-1:0] baud_cnt;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign done    = (state == U_STOP) && bit_end;
    assign busy    = (state != U_IDLE) && !done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= U_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            tx       <= 1'b1;
        end else if (start && !busy) begin
            state    <= U_START;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= tx_byte;
            tx       <= 1'b0;
        end else if (state != U_IDLE) begin
            if (bit_end) begin
                baud_cnt <= '0;
                case (state)
                    U_START: begin
                        state <= U_DATA;
                        tx    <= shreg[0];
                    end
                    U_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            state   <= U_STOP;
                            bit_cnt <= 3'd0;
                            tx      <= 1'b1;
                        end else begin
                            // shreg[0] is always the bit on the wire
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end
                    default: begin
                        state <= U_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_out.sv
// midi_out: MIDI 1.0 channel-message transmitter (31250 baud, 8N1).
//   clk, rst   : clk50PLL, synchronous active-high reset
//   send       : request strobe, taken when ready=1 and ch_message is valid
//   ch_message : message type nibble (8..E)
//   chan       : MIDI channel
//   data1/2    : data bytes (7 bit); data2 unused for PROG / CH_PRESS
//   ready      : able to accept send
//   tx         : serial output, idle high
//   msg_done   : one-cycle pulse after the last stop bit of a message
//   dbg        : FSM / counter snapshot
//
// Handshake: a message is accepted on a clock edge where send=1, ready=1 and
// ch_message is a channel-voice type; everything else on send is dropped
// (nothing is queued). The start bit of the first byte is on the line in the
// cycle after acceptance, and ready stays low until the msg_done cycle.
module midi_out
    import midi_pkg::*;
#(
    parameter int CLK_DIV        = DEFAULT_CLK_DIV,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          send,
    input  logic [3:0]    ch_message,
    input  logic [3:0]    chan,
    input  logic [6:0]    data1,
    input  logic [6:0]    data2,
    output logic          ready,
    output logic          tx,
    output logic          msg_done,
    output midi_out_dbg_t dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state;
    logic [7:0] status_q;
    logic [6:0] d1_q;
    logic [6:0] d2_q;
    logic [1:0] byte_idx;     // 0 = status, 1 = data1, 2 = data2
    logic [1:0] last_idx;
    logic [7:0] last_status;
    logic       last_valid;   // last_status holds a status actually sent

    logic [7:0] status_in;
    logic       accept;
    logic       skip_status;
    logic [1:0] next_idx;

    logic       uart_start;
    logic [7:0] uart_byte;
    logic       uart_busy;
    logic       uart_done;
    logic [1:0] uart_state;
    logic [2:0] uart_bit_cnt;

    assign status_in   = {ch_message, chan};
    assign ready       = (state == ST_IDLE) || (state == ST_DONE);
    assign msg_done    = (state == ST_DONE);
    assign accept      = send && ready && is_channel_msg(ch_message);
    assign skip_status = RUNNING_STATUS && last_valid && (last_status == status_in);
    assign next_idx    = byte_idx + 2'd1;

    // The first byte is fed straight from the inputs so its start bit lands
    // one cycle after acceptance; later bytes are handed over in the final
    // stop-bit cycle of the previous one so frames are back-to-back.
    always_comb begin
        uart_start = 1'b0;
        uart_byte  = status_q;
        if (accept) begin
            uart_start = 1'b1;
            uart_byte  = skip_status ? {1'b0, data1} : status_in;
        end else if (state == ST_BUSY && uart_done && byte_idx != last_idx) begin
            uart_start = 1'b1;
            case (next_idx)
                2'd1:    uart_byte = {1'b0, d1_q};
                2'd2:    uart_byte = {1'b0, d2_q};
                default: uart_byte = status_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            status_q    <= 8'h00;
            d1_q        <= 7'h00;
            d2_q        <= 7'h00;
            byte_idx    <= 2'd0;
            last_idx    <= 2'd0;
            last_status <= 8'h00;
            last_valid  <= 1'b0;
        end else begin
            case (state)
                ST_BUSY: begin
                    if (uart_done) begin
                        if (byte_idx == last_idx) begin
                            state    <= ST_DONE;
                            byte_idx <= 2'd0;
                        end else begin
                            byte_idx <= next_idx;
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        state       <= ST_BUSY;
                        status_q    <= status_in;
                        d1_q        <= data1;
                        d2_q        <= data2;
                        byte_idx    <= skip_status ? 2'd1 : 2'd0;
                        last_idx    <= msg_len(ch_message);
                        last_status <= status_in;
                        last_valid  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (uart_start),
        .tx_byte (uart_byte),
        .tx      (tx),
        .busy    (uart_busy),
        .done    (uart_done),
        .state   (uart_state),
        .bit_cnt (uart_bit_cnt)
    );

    assign dbg.fsm       = state;
    assign dbg.byte_idx  = byte_idx;
    assign dbg.uart_fsm  = uart_state;
    assign dbg.bit_cnt   = uart_bit_cnt;
    assign dbg.uart_busy = uart_busy;

endmodule

// File: tb/tb_midi_out.sv
module tb_midi_out;
    import midi_pkg::*;

    localparam int D_FAST = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       send_a, send_b, send_c;
    logic [3:0] ch_message, chan;
    logic [6:0] data1, data2;

    logic ready_a, tx_a, done_a;
    logic ready_b, tx_b, done_b;
    logic ready_c, tx_c, done_c;
    midi_out_dbg_t dbg_a, dbg_b, dbg_c;

    int   sel;
    logic obs_tx, obs_ready, obs_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] m_last[3];
    logic       m_valid[3];
    logic       m_rs[3];

    // clock / reset
    always #5 clk = ~clk;

    midi_out #(.CLK_DIV(D_FAST), .RUNNING_STATUS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .send(send_a), .ch_message(ch_message), .chan(chan),
        .data1(data1), .data2(data2), .ready(ready_a), .tx(tx_a), .msg_done(done_a), .dbg(dbg_a));
    midi_out #(.CLK_DIV(D_FAST), .RUNNING_STATUS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .send(send_b), .ch_message(ch_message), .chan(chan),
        .data1(data1), .data2(data2), .ready(ready_b), .tx(tx_b), .msg_done(done_b), .dbg(dbg_b));
    midi_out dut_c (
        .clk(clk), .rst(rst), .send(send_c), .ch_message(ch_message), .chan(chan),
        .data1(data1), .data2(data2), .ready(ready_c), .tx(tx_c), .msg_done(done_c), .dbg(dbg_c));

    always_comb begin
        obs_tx    = tx_a;
        obs_ready = ready_a;
        obs_done  = done_a;
        if (sel == 1) begin
            obs_tx = tx_b; obs_ready = ready_b; obs_done = done_b;
        end else if (sel == 2) begin
            obs_tx = tx_c; obs_ready = ready_c; obs_done = done_c;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_send(input int d, input logic v);
        if (d == 0) send_a = v;
        else if (d == 1) send_b = v;
        else send_c = v;
    endtask

    // Reference model: bytes a MIDI transmitter puts on the wire.
    task automatic model_expect(input int d, input logic [3:0] cm, input logic [3:0] ch,
                                input logic [6:0] d1, input logic [6:0] d2);
        logic [7:0] st;
        exp_q.delete();
        if (cm >= 4'h8 && cm <= 4'hE) begin
            st = {cm, ch};
            if (!(m_rs[d] && m_valid[d] && m_last[d] == st)) exp_q.push_back(st);
            exp_q.push_back({1'b0, d1});
            if (!(cm == 4'hC || cm == 4'hD)) exp_q.push_back({1'b0, d2});
            m_last[d]  = st;
            m_valid[d] = 1'b1;
        end
    endtask

    // Send one message to DUT d and receive it with a mid-bit sampling UART.
    // poke_t: cycle (from first start bit) at which a second send is tried.
    // rst_t : cycle at which rst is pulsed, abandoning the message.
    task automatic run_msg(input int d, input logic [3:0] cm, input logic [3:0] ch,
                           input logic [6:0] d1, input logic [6:0] d2,
                           input int poke_t, input int rst_t);
        int div, n, t, ts, off, slot, dur, budget;
        logic rx_active, fin, ready_bad, frame_bad, bad;
        logic [7:0] sh;
        sel = d;
        div = (d == 2) ? DEFAULT_CLK_DIV : D_FAST;
        model_expect(d, cm, ch, d1, d2);
        n = exp_q.size();
        got_q.delete();
        @(negedge clk);
        ch_message = cm; chan = ch; data1 = d1; data2 = d2;
        drive_send(d, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_send(d, 1'b0);
        if (n == 0) begin
            bad = 1'b0;
            for (int i = 0; i < 3 * div; i++) begin
                if (obs_tx !== 1'b1 || obs_ready !== 1'b1 || obs_done !== 1'b0) bad = 1'b1;
                @(negedge clk);
            end
            check("ignored_send_idle", 32'(bad), 32'd0);
            return;
        end
        check("start_latency_tx", 32'(obs_tx), 32'd0);
        check("ready_low_after_accept", 32'(obs_ready), 32'd0);
        t = 0; ts = 0; dur = -1; sh = 8'h00;
        rx_active = 1'b0; fin = 1'b0; ready_bad = 1'b0; frame_bad = 1'b0;
        budget = n * 10 * div + 4 * div;
        while (!fin && t < budget) begin
            if (t == rst_t) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("rst_tx_high", 32'(obs_tx), 32'd1);
                check("rst_ready_high", 32'(obs_ready), 32'd1);
                check("rst_msg_done_low", 32'(obs_done), 32'd0);
                rst = 1'b0;
                for (int k = 0; k < 3; k++) m_valid[k] = 1'b0;
                return;
            end
            if (t == poke_t) begin
                ch_message = 4'h9; chan = ~ch; data1 = ~d1; data2 = ~d2;
                drive_send(d, 1'b1);
            end
            if (t == poke_t + 1) begin
                ch_message = cm; chan = ch; data1 = d1; data2 = d2;
                drive_send(d, 1'b0);
            end
            if (!rx_active && obs_tx === 1'b0) begin
                rx_active = 1'b1;
                ts = t;
            end
            if (rx_active) begin
                off = t - ts;
                if (off == div / 2 && obs_tx !== 1'b0) frame_bad = 1'b1;
                if (off > div / 2 && (off - div / 2) % div == 0) begin
                    slot = (off - div / 2) / div;
                    if (slot <= 8) begin
                        sh[slot-1] = obs_tx;
                    end else begin
                        if (obs_tx !== 1'b1) frame_bad = 1'b1;
                        got_q.push_back(sh);
                        rx_active = 1'b0;
                    end
                end
            end
            if (obs_done === 1'b1) begin
                dur = t;
                fin = 1'b1;
                check("ready_in_done_cycle", 32'(obs_ready), 32'd1);
            end else begin
                if (obs_ready !== 1'b0) ready_bad = 1'b1;
                @(negedge clk);
                t++;
            end
        end
        check("msg_done_seen", 32'(fin), 32'd1);
        check("duration", 32'(dur), 32'(n * 10 * div));
        check("byte_count", 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check("frame_start_stop", 32'(frame_bad), 32'd0);
        check("ready_low_while_busy", 32'(ready_bad), 32'd0);
        @(negedge clk);
        check("msg_done_one_cycle", 32'(obs_done), 32'd0);
        check("idle_tx_high", 32'(obs_tx), 32'd1);
    endtask

    initial begin : stimulus
        logic [13:0] pitch_val;
        int r, d;
        logic [3:0] cm;
        rst = 1'b1;
        send_a = 1'b0; send_b = 1'b0; send_c = 1'b0;
        ch_message = 4'h0; chan = 4'h0; data1 = 7'h00; data2 = 7'h00;
        sel = 0;
        m_rs[0] = 1'b1; m_rs[1] = 1'b0; m_rs[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 1'b0;
            m_last[k]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx_a", 32'(tx_a), 32'd1);
        check("reset_ready_a", 32'(ready_a), 32'd1);
        check("reset_done_a", 32'(done_a), 32'd0);
        check("reset_tx_b", 32'(tx_b), 32'd1);
        check("reset_ready_c", 32'(ready_c), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Note On, program change
        run_msg(0, 4'h9, 4'h0, 7'd60, 7'd100, -1, -1);
        run_msg(0, 4'hC, 4'h5, 7'h10, 7'h55, -1, -1);

        // running status on/off
        run_msg(0, 4'h9, 4'h3, 7'd60, 7'd100, -1, -1);
        run_msg(0, 4'h9, 4'h3, 7'd62, 7'd90, -1, -1);
        run_msg(0, 4'h8, 4'h3, 7'd60, 7'd0, -1, -1);
        run_msg(1, 4'h9, 4'h3, 7'd60, 7'd100, -1, -1);
        run_msg(1, 4'h9, 4'h3, 7'd62, 7'd90, -1, -1);
        run_msg(1, 4'h8, 4'h3, 7'd60, 7'd0, -1, -1);

        // invalid type nibbles, send while busy
        run_msg(0, 4'h0, 4'h1, 7'd1, 7'd2, -1, -1);
        run_msg(0, 4'hF, 4'h1, 7'd1, 7'd2, -1, -1);
        run_msg(0, 4'hB, 4'h1, 7'd7, 7'd127, 3 * D_FAST, -1);

        // reset in byte 2 bit 4, then the same Note On resends its status
        run_msg(0, 4'h9, 4'h2, 7'd40, 7'd50, -1, -1);
        run_msg(0, 4'h9, 4'h2, 7'd40, 7'd50, -1, 10 * D_FAST + 5 * D_FAST + D_FAST / 2);
        run_msg(0, 4'h9, 4'h2, 7'd40, 7'd50, -1, -1);

        // pitch bend, decoded as midi_in would
        run_msg(0, 4'hE, 4'hF, 7'h00, 7'h40, -1, -1);
        pitch_val = (got_q.size() >= 2) ?
            {got_q[got_q.size()-1][6:0], got_q[got_q.size()-2][6:0]} : 14'h3FFF;
        check("pitch_loopback", 32'(pitch_val), 32'h2000);

        // random messages
        for (int i = 0; i < 12; i++) begin
            d = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            cm = (r < 7) ? 4'(8 + r) : ((r == 7) ? 4'h0 : ((r == 8) ? 4'hF : 4'h3));
            run_msg(d, cm, 4'($urandom_range(0, 2)), 7'($urandom_range(0, 127)),
                    7'($urandom_range(0, 127)), -1, -1);
        end

        // default baud divisor: 3 bytes = 48000 clocks
        run_msg(2, 4'h9, 4'h0, 7'd60, 7'd100, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
